// File: rtl/iob_eth_mem_arb.sv
// iob_eth_mem_arb
// Arbitrates one single-port buffer RAM between a CPU native-bus requester
// and an Ethernet MAC Wishbone master.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   c_*               CPU request (valid/addr/wdata/wstrb) and response (rdata/ready)
//   m_*               MAC Wishbone request (cyc/stb/we/sel/adr/dat_i) and response (dat_o/ack)
//   ram_*             RAM strobe, address, byte write enables, write data, read data
//   gnt_mac           high while the MAC owns the access in flight
//   wait_cnt          saturating count of cycles in which a pending request was denied
//
// Handshake: a requester raises c_valid (or m_cyc&m_stb) and holds it with
// stable address/data until it sees its single-cycle c_ready (or m_ack);
// read data is valid only in that completion cycle and is 0 otherwise.
// Every access takes two cycles: IDLE issues the RAM strobe for the winner,
// RESP returns the RAM output and completes the winner's handshake.
module iob_eth_mem_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_valid,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_wstrb,
  output logic [DATA_W-1:0]   c_rdata,
  output logic                c_ready,
  input  logic                m_cyc,
  input  logic                m_stb,
  input  logic                m_we,
  input  logic [DATA_W/8-1:0] m_sel,
  input  logic [ADDR_W-1:0]   m_adr,
  input  logic [DATA_W-1:0]   m_dat_i,
  output logic [DATA_W-1:0]   m_dat_o,
  output logic                m_ack,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic                gnt_mac,
  output logic [15:0]         wait_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        win_mac_q, win_mac_d;    // winner of the access in flight
  logic        last_mac_q, last_mac_d;  // winner of the most recent grant
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic c_req, m_req, pick_mac, deny;

  always_comb begin
    c_req = c_valid;
    m_req = m_cyc & m_stb;
    // Round robin: on a tie the requester that did not win last time goes.
    pick_mac = m_req & (~c_req | ~last_mac_q);
    deny     = 1'b0;

    state_d    = state_q;
    win_mac_d  = win_mac_q;
    last_mac_d = last_mac_q;

    ram_en   = 1'b0;
    ram_addr = '0;
    ram_we   = '0;
    ram_din  = '0;
    c_ready  = 1'b0;
    c_rdata  = '0;
    m_ack    = 1'b0;
    m_dat_o  = '0;
    gnt_mac  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (c_req | m_req) begin
          ram_en = 1'b1;
          if (pick_mac) begin
            ram_addr = m_adr;
            ram_din  = m_dat_i;
            ram_we   = m_we ? m_sel : '0;
          end else begin
            ram_addr = c_addr;
            ram_din  = c_wdata;
            ram_we   = c_wstrb;
          end
          win_mac_d  = pick_mac;
          last_mac_d = pick_mac;
          state_d    = ST_RESP;
          deny       = c_req & m_req;
        end
      end
      ST_RESP: begin
        gnt_mac = win_mac_q;
        state_d = ST_IDLE;
        if (win_mac_q) begin
          m_ack   = 1'b1;
          m_dat_o = ram_dout;
          deny    = c_req;
        end else begin
          c_ready = 1'b1;
          c_rdata = ram_dout;
          deny    = m_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wait_cnt_d = (deny && (wait_cnt_q != 16'hFFFF)) ? wait_cnt_q + 16'd1 : wait_cnt_q;
    wait_cnt   = wait_cnt_q;

    // Outputs are forced quiet for the whole time reset is held, including
    // the request-driven RAM strobe that would otherwise follow IDLE.
    if (rst) begin
      ram_en   = 1'b0;
      ram_addr = '0;
      ram_we   = '0;
      ram_din  = '0;
      c_ready  = 1'b0;
      c_rdata  = '0;
      m_ack    = 1'b0;
      m_dat_o  = '0;
      gnt_mac  = 1'b0;
      wait_cnt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_mac_q  <= 1'b0;
      last_mac_q <= 1'b0;  // CPU counts as last winner, so the MAC takes the first tie
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      win_mac_q  <= win_mac_d;
      last_mac_q <= last_mac_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_mem_arb.sv
module tb_iob_eth_mem_arb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                c_valid = 1'b0;
  logic [ADDR_W-1:0]   c_addr = '0;
  logic [DATA_W-1:0]   c_wdata = '0;
  logic [DATA_W/8-1:0] c_wstrb = '0;
  logic [DATA_W-1:0]   c_rdata;
  logic                c_ready;
  logic                m_cyc = 1'b0;
  logic                m_stb = 1'b0;
  logic                m_we = 1'b0;
  logic [DATA_W/8-1:0] m_sel = '0;
  logic [ADDR_W-1:0]   m_adr = '0;
  logic [DATA_W-1:0]   m_dat_i = '0;
  logic [DATA_W-1:0]   m_dat_o;
  logic                m_ack;
  logic                ram_en;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W/8-1:0] ram_we;
  logic [DATA_W-1:0]   ram_din;
  logic [DATA_W-1:0]   ram_dout;
  logic                gnt_mac;
  logic [15:0]         wait_cnt;

  int checks = 0;
  int failures = 0;

  iob_eth_mem_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .gnt_mac(gnt_mac), .wait_cnt(wait_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Byte-writable RAM, read-first, registered output.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c_valid = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0; m_adr = '0; m_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    c_valid = 1'b1; c_addr = 11'd4; c_wstrb = 4'hF; c_wdata = 32'h12345678;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_adr = 11'd6;
    step(); #1;
    checks++;
    if ({ram_en, c_ready, m_ack, gnt_mac} !== 4'b0000) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=0000", {ram_en, c_ready, m_ack, gnt_mac});
    end
    checks++;
    if ({ram_addr, ram_we, ram_din, c_rdata, m_dat_o, wait_cnt} !== '0) begin
      failures++; $display("FAIL rst_data got addr=%h we=%h din=%h wc=%h exp all 0",
                           ram_addr, ram_we, ram_din, wait_cnt);
    end
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    c_valid = 1'b1; c_addr = 11'd5; c_wdata = 32'hDEADBEEF; c_wstrb = 4'hF;
    #1;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 4'hF, 11'd5, 32'hDEADBEEF}) begin
      failures++; $display("FAIL cpu_wr_issue got en=%b we=%h addr=%h din=%h exp 1 f 005 deadbeef",
                           ram_en, ram_we, ram_addr, ram_din);
    end
    step(); #1;
    checks++;
    if ({c_ready, m_ack} !== 2'b10) begin
      failures++; $display("FAIL cpu_wr_ready got rdy=%b ack=%b exp 1 0", c_ready, m_ack);
    end
    c_wstrb = 4'h0;  // becomes a read; ignored until IDLE
    step(); #1;
    checks++;
    if ({ram_en, ram_we, ram_addr, c_ready, c_rdata} !== {1'b1, 4'h0, 11'd5, 1'b0, 32'h0}) begin
      failures++; $display("FAIL cpu_rd_issue got en=%b we=%h addr=%h rdy=%b rdata=%h exp 1 0 005 0 0",
                           ram_en, ram_we, ram_addr, c_ready, c_rdata);
    end
    step(); #1;
    checks++;
    if ({c_ready, m_ack, c_rdata, m_dat_o} !== {1'b1, 1'b0, 32'hDEADBEEF, 32'h0}) begin
      failures++; $display("FAIL cpu_rd_data got rdy=%b ack=%b rdata=%h mdat=%h exp 1 0 deadbeef 0",
                           c_ready, m_ack, c_rdata, m_dat_o);
    end
    c_valid = 1'b0;
    step();
  endtask

  task automatic test_first_tie();
    do_reset();
    c_valid = 1'b1; c_addr = 11'd7; c_wstrb = 4'h0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 11'd9;
    #1;
    checks++;
    if ({ram_en, ram_addr, gnt_mac, wait_cnt} !== {1'b1, 11'd9, 1'b0, 16'd0}) begin
      failures++; $display("FAIL tie_issue got en=%b addr=%h gnt=%b wc=%h exp 1 009 0 0000",
                           ram_en, ram_addr, gnt_mac, wait_cnt);
    end
    step(); #1;
    checks++;
    if ({gnt_mac, m_ack, c_ready, ram_en} !== 4'b1100) begin
      failures++; $display("FAIL tie_mac_resp got gnt=%b ack=%b rdy=%b en=%b exp 1100",
                           gnt_mac, m_ack, c_ready, ram_en);
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    step(); #1;
    checks++;
    if ({ram_en, ram_addr, gnt_mac} !== {1'b1, 11'd7, 1'b0}) begin
      failures++; $display("FAIL tie_cpu_issue got en=%b addr=%h gnt=%b exp 1 007 0", ram_en, ram_addr, gnt_mac);
    end
    step(); #1;
    checks++;
    if ({c_ready, m_ack, gnt_mac, wait_cnt} !== {3'b100, 16'd2}) begin
      failures++; $display("FAIL tie_cpu_resp got rdy=%b ack=%b gnt=%b wc=%0d exp 1 0 0 2",
                           c_ready, m_ack, gnt_mac, wait_cnt);
    end
    c_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int mac_n = 0;
    int cpu_n = 0;
    do_reset();
    c_valid = 1'b1; c_addr = 11'd20; c_wstrb = 4'h0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 11'd21;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({ram_en, gnt_mac} !== 2'b10) begin
        failures++; $display("FAIL b2b_issue[%0d] got en=%b gnt=%b exp 1 0", i, ram_en, gnt_mac);
      end
      step(); #1;
      checks++;
      if ({m_ack, c_ready} !== (((i % 2) == 0) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL b2b_order[%0d] got ack=%b rdy=%b exp %s", i, m_ack, c_ready,
                             ((i % 2) == 0) ? "mac" : "cpu");
      end
      if (m_ack) mac_n++;
      if (c_ready) cpu_n++;
      step();
    end
    #1;
    checks++;
    if (mac_n != 4 || cpu_n != 4) begin
      failures++; $display("FAIL b2b_share got mac=%0d cpu=%0d exp 4 4", mac_n, cpu_n);
    end
    checks++;
    if (wait_cnt !== 16'd16) begin
      failures++; $display("FAIL b2b_wait got=%0d exp=16", wait_cnt);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_mac_byte_mask();
    do_reset();
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_adr = 11'd12; m_dat_i = 32'h11223344;
    #1;
    checks++;
    if ({ram_en, ram_we, ram_din} !== {1'b1, 4'hF, 32'h11223344}) begin
      failures++; $display("FAIL mac_full_wr got en=%b we=%h din=%h exp 1 f 11223344", ram_en, ram_we, ram_din);
    end
    step();
    m_sel = 4'b0011; m_dat_i = 32'hAABBCCDD;
    step(); #1;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 4'b0011, 11'd12, 32'hAABBCCDD}) begin
      failures++; $display("FAIL mac_part_wr got en=%b we=%h addr=%h din=%h exp 1 3 00c aabbccdd",
                           ram_en, ram_we, ram_addr, ram_din);
    end
    step();
    m_we = 1'b0; m_sel = 4'hF;
    step(); #1;
    checks++;
    if ({ram_en, ram_we, m_ack, m_dat_o} !== {1'b1, 4'h0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL mac_rd_issue got en=%b we=%h ack=%b mdat=%h exp 1 0 0 0",
                           ram_en, ram_we, m_ack, m_dat_o);
    end
    step(); #1;
    checks++;
    if ({m_ack, c_ready, m_dat_o, c_rdata} !== {2'b10, 32'h1122CCDD, 32'h0}) begin
      failures++; $display("FAIL mac_rd_data got ack=%b rdy=%b mdat=%h crd=%h exp 1 0 1122ccdd 0",
                           m_ack, c_ready, m_dat_o, c_rdata);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    c_valid = 1'b1; c_addr = 11'd3; c_wstrb = 4'h0;
    step();        // now in RESP for the CPU
    rst = 1'b1;
    #1;
    checks++;
    if ({c_ready, m_ack, ram_en, gnt_mac, c_rdata} !== '0) begin
      failures++; $display("FAIL rst_resp_drop got rdy=%b ack=%b en=%b gnt=%b rdata=%h exp all 0",
                           c_ready, m_ack, ram_en, gnt_mac, c_rdata);
    end
    step(); #1;
    checks++;
    if ({c_ready, ram_en} !== 2'b00) begin
      failures++; $display("FAIL rst_resp_hold got rdy=%b en=%b exp 0 0", c_ready, ram_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ram_en, ram_addr, c_ready} !== {1'b1, 11'd3, 1'b0}) begin
      failures++; $display("FAIL rst_resp_regrant got en=%b addr=%h rdy=%b exp 1 003 0", ram_en, ram_addr, c_ready);
    end
    step(); #1;
    checks++;
    if (c_ready !== 1'b1) begin
      failures++; $display("FAIL rst_resp_ready got=%b exp=1", c_ready);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_wait_saturate();
    do_reset();
    c_valid = 1'b1; c_addr = 11'd1;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 11'd2;
    repeat (65534) step();
    #1;
    checks++;
    if (wait_cnt !== 16'hFFFE) begin
      failures++; $display("FAIL sat_below got=%h exp=fffe", wait_cnt);
    end
    step(); #1;
    checks++;
    if (wait_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_reach got=%h exp=ffff", wait_cnt);
    end
    repeat (5) step();
    #1;
    checks++;
    if (wait_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold got=%h exp=ffff", wait_cnt);
    end
    clear_inputs();
    step();
  endtask

  // m_ack must never accompany a CPU-only stretch; tracked in test_cpu_write_read
  // by direct checks of m_ack in each response cycle.

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cpu_write_read();
    test_first_tie();
    test_back_to_back();
    test_mac_byte_mask();
    test_reset_in_resp();
    test_wait_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
